window_line_buffer_3x3: RTL and testbench
=========================================

# window_line_buffer_3x3

Streaming 3x3 window source for stencil cores in HIR-generated datapaths. It accepts one pixel per write-port beat, keeps the two previous image lines in internal line memories, and presents the current 3x3 neighbourhood on a 3x3 array of zero-latency read ports. It is the responder side of the 3x3 `i_rd_en`/`i_rd_data` window interface used by `weighted_average`-style consumers. It also flags windows that were overwritten without being read.

## Interface

Parameters:
- ELEMENT_WIDTH, 32: pixel width in bits.
- IMG_WIDTH, 16: pixels per image line. Must be ≥3.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-low.
- t  input  1  frame-start time pulse; realigns the position counters.
- p1_wr_en  input  1  pixel write strobe.
- p1_wr_data  input  ELEMENT_WIDTH  pixel value, row-major order.
- p0_rd_en  input  [2:0][2:0] x 1  per-tap read enables.
- p0_rd_data  output  [2:0][2:0] x ELEMENT_WIDTH  window taps; [row][col], [0][0] is oldest/leftmost.
- window_valid  output  1  the window holds a complete, in-image neighbourhood.
- overrun  output  1  sticky error flag.

## Operation

- State:
  - col counter, 0..IMG_WIDTH-1.
  - row counter, 2-bit, saturates at 2.
  - Line memories line0 (row r-1) and line1 (row r-2), IMG_WIDTH entries each, no reset.
  - 3x3 window register array win.
  - window_valid, consumed, overrun.
- Write at position c, on a cycle with p1_wr_en=1:
  - Shift win left by one column: win[i][0] <= win[i][1], win[i][1] <= win[i][2].
  - Load the new column: win[0][2] <= line1[c], win[1][2] <= line0[c], win[2][2] <= p1_wr_data.
  - Update the line memories: line1[c] <= line0[c], line0[c] <= p1_wr_data.
  - Advance position: col <= c+1, wrapping to 0 after IMG_WIDTH-1. On wrap, row <= min(row+1, 2).
  - window_valid <= (row==2 && c≥2). The row check uses the pre-increment row.
- No write: win, the line memories, the counters and window_valid hold.
- Reads: p0_rd_data[i][j] = p0_rd_en[i][j] ? win[i][j] : 0. This is combinational, zero-latency and side-effect free, except for the consumed flag.
- consumed:
  - Set on any cycle with window_valid=1 and any p0_rd_en bit high.
  - Cleared on every write.
- overrun:
  - Set on a write when window_valid=1, consumed=0 and no p0_rd_en bit is high in that cycle.
  - Sticky; cleared only by reset or t.
- t:
  - t alone: col <= 0, row <= 0, window_valid <= 0, consumed <= 0, overrun <= 0.
  - t with p1_wr_en in the same cycle: the write is processed as position (row 0, col 0), then col <= 1. t takes priority over the current counter values.
- Line-start columns 0 and 1 mix the tail of the previous line into win. window_valid is low for them by rule.
- Rows 0–1 read uninitialised line-memory data. window_valid is low for them by rule.

## Timing

- Reset (rst=0 at posedge):
  - col=0, row=0.
  - All win taps = 0, so p0_rd_data is all 0 regardless of enables.
  - window_valid=0, consumed=0, overrun=0.
  - Line memories keep their contents.
- Reset mid-frame aborts the frame. The next frame restarts from (0,0) with no further action; a t pulse is optional.
- Write-to-window latency: a pixel written in cycle N is visible at win[2][2] and in window_valid from cycle N+1.
- Throughput: one pixel per cycle, back-to-back writes allowed. Line-memory read and write to the same address in the same cycle return the old contents (read-before-write).
- Reads in cycle N return win as of cycle N. A concurrent write does not affect them.
- Column wrap and row saturation happen in the same cycle as the last-column write.

## Test plan

Common setup: IMG_WIDTH=4, pixel value = row*4 + col + 1.

- Reset: assert rst=0 for 2 cycles with all p0_rd_en=1 -> every p0_rd_data = 0, window_valid=0, overrun=0.
- First valid window: pulse t, then write 1..11 on consecutive cycles with all p0_rd_en=1.
  - Cycle after writing 11 -> window_valid=1, rows {1,2,3}/{5,6,7}/{9,10,11}.
  - After writing 12 -> {2,3,4}/{6,7,8}/{10,11,12}, valid=1.
- Line wrap: continue the previous scenario.
  - After writing 13 and 14 -> window_valid=0.
  - After writing 15 -> {5,6,7}/{9,10,11}/{13,14,15}, valid=1.
- Read gating: with the window {1,2,3}/{5,6,7}/{9,10,11}, set only p0_rd_en[1][1]=1 -> p0_rd_data[1][1]=6, all other taps 0.
- Overrun:
  - With window_valid=1, write the next pixel with all p0_rd_en=0 and no read since the last write -> overrun=1 next cycle.
  - overrun stays 1 through later reads.
  - A t pulse clears it.
- t with write, and reset mid-frame:
  - After 6 writes, assert t together with p1_wr_en (value 1), then write 2..11 -> same windows as the first-valid-window scenario.
  - Repeat with rst=0 after 9 writes -> valid stays 0 until 11 fresh writes.

Source files
------------

// File: rtl/window_line_buffer_3x3.sv
// Streaming 3x3 window source: two line memories feed a 3x3 shift window,
// exposed through gated zero-latency taps, with an overrun flag for windows lost unread.
module window_line_buffer_3x3 #(
  parameter int unsigned ELEMENT_WIDTH = 32,
  parameter int unsigned IMG_WIDTH     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                t,
  input  logic                                p1_wr_en,
  input  logic [ELEMENT_WIDTH-1:0]            p1_wr_data,
  input  logic [2:0][2:0]                     p0_rd_en,
  output logic [2:0][2:0][ELEMENT_WIDTH-1:0]  p0_rd_data,
  output logic                                window_valid,
  output logic                                overrun
);

  localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  typedef logic [CW-1:0] col_t;
  localparam col_t LAST_COL = col_t'(IMG_WIDTH - 1);

  col_t       col_q, col_d, pos_col;
  logic [1:0] row_q, row_d, pos_row;

  logic [ELEMENT_WIDTH-1:0] line0_q [IMG_WIDTH];
  logic [ELEMENT_WIDTH-1:0] line1_q [IMG_WIDTH];

  logic [2:0][2:0][ELEMENT_WIDTH-1:0] win_q, win_d;
  logic valid_q, valid_d;
  logic consumed_q, consumed_d;
  logic overrun_q, overrun_d;
  logic any_rd;

  assign any_rd = |p0_rd_en;

  // A t pulse coinciding with a write forces that write to land at (row 0, col 0).
  assign pos_col = t ? '0 : col_q;
  assign pos_row = t ? '0 : row_q;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    win_d      = win_q;
    valid_d    = valid_q;
    consumed_d = consumed_q;
    overrun_d  = overrun_q;

    if (t) begin
      col_d      = '0;
      row_d      = '0;
      valid_d    = 1'b0;
      consumed_d = 1'b0;
      overrun_d  = 1'b0;
    end else if (valid_q && any_rd) begin
      consumed_d = 1'b1;
    end

    if (p1_wr_en) begin
      for (int unsigned i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = line1_q[pos_col];
      win_d[1][2] = line0_q[pos_col];
      win_d[2][2] = p1_wr_data;

      if (pos_col == LAST_COL) begin
        col_d = '0;
        row_d = (pos_row == 2'd2) ? 2'd2 : pos_row + 2'd1;
      end else begin
        col_d = pos_col + col_t'(1);
      end

      valid_d    = (pos_row == 2'd2) && (pos_col >= col_t'(2));
      consumed_d = 1'b0;
      if (!t && valid_q && !consumed_q && !any_rd) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      valid_q    <= 1'b0;
      consumed_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      valid_q    <= valid_d;
      consumed_q <= consumed_d;
      overrun_q  <= overrun_d;
    end
  end

  // Line memories are not reset; reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst && p1_wr_en) begin
      line1_q[pos_col] <= line0_q[pos_col];
      line0_q[pos_col] <= p1_wr_data;
    end
  end

  always_comb begin
    p0_rd_data = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        p0_rd_data[i][j] = p0_rd_en[i][j] ? win_q[i][j] : '0;
      end
    end
  end

  assign window_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_window_line_buffer_3x3.sv
// Self-checking bench for window_line_buffer_3x3: directed plan scenarios plus
// randomized traffic against a frame-indexed reference model.
module tb_window_line_buffer_3x3;
  localparam int EW = 32;
  localparam int W  = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      t;
  logic                      p1_wr_en;
  logic [EW-1:0]             p1_wr_data;
  logic [2:0][2:0]           p0_rd_en;
  logic [2:0][2:0][EW-1:0]   p0_rd_data;
  logic                      window_valid;
  logic                      overrun;

  always #5 clk = ~clk;

  window_line_buffer_3x3 #(.ELEMENT_WIDTH(EW), .IMG_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .t(t), .p1_wr_en(p1_wr_en), .p1_wr_data(p1_wr_data),
    .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data),
    .window_valid(window_valid), .overrun(overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pixels of the current frame in arrival order, position (R,c)
  // with R unbounded, and the three most recent pixels since reset.
  int unsigned frame[$];
  logic [EW-1:0] hist[$];
  int  m_row, m_col;
  bit  m_init = 0, m_valid, m_read, m_ovr, m_zero;
  logic [EW-1:0] m_win [3][3];

  task automatic model_edge(bit rn, bit tt, bit wr, logic [EW-1:0] d, logic [8:0] en);
    bit any;
    any = |en;
    if (!rn) begin
      m_init = 1; m_row = 0; m_col = 0; frame.delete();
      hist.delete(); for (int k = 0; k < 3; k++) hist.push_back('0);
      m_valid = 0; m_read = 0; m_ovr = 0; m_zero = 1;
      return;
    end
    if (m_valid && any) m_read = 1;
    if (tt) begin
      m_row = 0; m_col = 0; frame.delete();
      m_valid = 0; m_read = 0; m_ovr = 0;
    end
    if (wr) begin
      if (!tt && m_valid && !m_read && !any) m_ovr = 1;
      frame.push_back(d);
      hist.push_back(d); void'(hist.pop_front());
      m_zero  = 0;
      m_valid = (m_row >= 2) && (m_col >= 2);
      if (m_valid)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            m_win[i][j] = frame[(m_row - 2 + i) * W + m_col - 2 + j];
      m_col++;
      if (m_col == W) begin m_col = 0; m_row++; end
      m_read = 0;
    end
  endtask

  task automatic check_outputs(string tag);
    logic [EW-1:0] e;
    if (!m_init) return;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        if (m_valid)     e = p0_rd_en[i][j] ? m_win[i][j] : '0;
        else if (m_zero) e = '0;
        else if (i == 2) e = p0_rd_en[i][j] ? hist[j] : '0;
        else continue;
        n_tests++;
        if (p0_rd_data[i][j] !== e) begin
          n_fail++;
          $display("FAIL %s tap[%0d][%0d]: got %0h expected %0h", tag, i, j, p0_rd_data[i][j], e);
        end
      end
    n_tests++;
    if (window_valid !== m_valid) begin
      n_fail++;
      $display("FAIL %s window_valid: got %b expected %b", tag, window_valid, m_valid);
    end
    n_tests++;
    if (overrun !== m_ovr) begin
      n_fail++;
      $display("FAIL %s overrun: got %b expected %b", tag, overrun, m_ovr);
    end
  endtask

  task automatic step(string tag, bit rn, bit tt, bit wr, logic [EW-1:0] d, logic [8:0] en);
    @(negedge clk);
    rst = rn; t = tt; p1_wr_en = wr; p1_wr_data = d; p0_rd_en = en;
    #1 check_outputs(tag);
    @(posedge clk);
    model_edge(rn, tt, wr, d, en);
  endtask

  task automatic write_run(string tag, int first, int last, logic [8:0] en);
    for (int k = first; k <= last; k++) step(tag, 1, 0, 1, EW'(k), en);
  endtask

  // Idle cycle with all taps enabled, compared against literal expectations.
  task automatic expect_win(string tag, int unsigned e[9], bit ev);
    @(negedge clk);
    rst = 1; t = 0; p1_wr_en = 0; p0_rd_en = '1;
    #1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        n_tests++;
        if (p0_rd_data[i][j] !== EW'(e[i*3+j])) begin
          n_fail++;
          $display("FAIL %s const tap[%0d][%0d]: got %0d expected %0d", tag, i, j, p0_rd_data[i][j], e[i*3+j]);
        end
      end
    n_tests++;
    if (window_valid !== ev) begin
      n_fail++;
      $display("FAIL %s const window_valid: got %b expected %b", tag, window_valid, ev);
    end
    check_outputs(tag);
    @(posedge clk);
    model_edge(1, 0, 0, '0, 9'h1FF);
  endtask

  task automatic peek_valid(string tag, bit ev);
    #1;
    n_tests++;
    if (window_valid !== ev) begin
      n_fail++;
      $display("FAIL %s window_valid: got %b expected %b", tag, window_valid, ev);
    end
  endtask

  task automatic test_reset();
    step("reset", 0, 0, 0, '0, 9'h1FF);
    step("reset", 0, 0, 0, '0, 9'h1FF);
    step("reset", 1, 0, 0, '0, 9'h1FF);
    n_tests++;
    if (p0_rd_data !== '0 || window_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%0h valid=%b ovr=%b expected all 0", p0_rd_data, window_valid, overrun);
    end
  endtask

  task automatic test_first_valid();
    int unsigned w11[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int unsigned w12[9] = '{2, 3, 4, 6, 7, 8, 10, 11, 12};
    int unsigned w15[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    step("first_t", 1, 1, 0, '0, 9'h1FF);
    write_run("first", 1, 11, 9'h1FF);
    expect_win("first_w11", w11, 1);
    write_run("first", 12, 12, 9'h1FF);
    expect_win("first_w12", w12, 1);
    write_run("wrap", 13, 13, 9'h1FF);
    peek_valid("wrap_13", 0);
    write_run("wrap", 14, 14, 9'h1FF);
    peek_valid("wrap_14", 0);
    write_run("wrap", 15, 15, 9'h1FF);
    expect_win("wrap_w15", w15, 1);
  endtask

  task automatic test_read_gating();
    step("gate_t", 1, 1, 0, '0, '0);
    write_run("gate", 1, 11, '0);
    @(negedge clk);
    p1_wr_en = 0; t = 0; p0_rd_en = '0; p0_rd_en[1][1] = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        n_tests++;
        if (p0_rd_data[i][j] !== ((i == 1 && j == 1) ? EW'(6) : EW'(0))) begin
          n_fail++;
          $display("FAIL gate tap[%0d][%0d]: got %0d expected %0d", i, j, p0_rd_data[i][j], (i == 1 && j == 1) ? 6 : 0);
        end
      end
    check_outputs("gate");
    @(posedge clk);
    model_edge(1, 0, 0, '0, 9'b000_010_000);
  endtask

  task automatic test_overrun();
    step("ovr_t", 1, 1, 0, '0, '0);
    write_run("ovr", 1, 12, '0);
    step("ovr_set", 1, 0, 0, '0, '0);
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    step("ovr_read", 1, 0, 0, '0, 9'h1FF);
    step("ovr_read", 1, 0, 0, '0, 9'h1FF);
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    step("ovr_t", 1, 1, 0, '0, '0);
    step("ovr_clr", 1, 0, 0, '0, '0);
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_t_with_write();
    int unsigned w11[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    write_run("twr_pre", 1, 6, 9'h1FF);
    step("twr_t", 1, 1, 1, EW'(1), 9'h1FF);
    write_run("twr", 2, 11, 9'h1FF);
    expect_win("twr_w11", w11, 1);
  endtask

  task automatic test_reset_mid_frame();
    int unsigned w11[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    step("mid_t", 1, 1, 0, '0, 9'h1FF);
    write_run("mid_pre", 1, 9, 9'h1FF);
    step("mid_rst", 0, 0, 0, '0, 9'h1FF);
    for (int k = 1; k <= 11; k++) begin
      step("mid", 1, 0, 1, EW'(k), 9'h1FF);
      peek_valid("mid_valid", k == 11);
    end
    expect_win("mid_w11", w11, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bit rn, tt, wr;
      rn = ($urandom_range(0, 199) != 0);
      tt = ($urandom_range(0, 59) == 0);
      wr = ($urandom_range(0, 9) < 7);
      step("rand", rn, tt, wr, $urandom, ($urandom_range(0, 3) == 0) ? 9'h0 : 9'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; t = 1'b0; p1_wr_en = 1'b0; p1_wr_data = '0; p0_rd_en = '1;
    test_reset();
    test_first_valid();
    test_read_gating();
    test_overrun();
    test_t_with_write();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
